// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg -- shared types and constants for the instruction-fetch controller.
//   fetch_state_t : controller state encoding
//   INSN_BYTES    : PC increment per fetched word
//   FQ_DEPTH      : number of entries in the fetch queue toward IF/ID
//   occ_after_pop : queue occupancy once this cycle's pop is taken into account
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_t;

  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned FQ_DEPTH   = 2;
  localparam int unsigned FQ_CNT_W   = 2;

  localparam logic [FQ_CNT_W-1:0] FQ_EMPTY = 2'd0;
  localparam logic [FQ_CNT_W-1:0] FQ_ONE   = 2'd1;
  localparam logic [FQ_CNT_W-1:0] FQ_FULL  = 2'd2;

  function automatic logic [FQ_CNT_W-1:0] occ_after_pop(
    input logic [FQ_CNT_W-1:0] occ,
    input logic                pop
  );
    return occ - {1'b0, pop};
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo -- 2-entry {pc, instr} queue between the fetch port and IF/ID.
// Entry 0 is always the head; a pop shifts entry 1 down. Clear wins over push.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   push, push_pc/instr    write a new entry (ignored when full without a pop)
//   pop                    drop the head entry (ignored when empty)
//   clear                  empty the queue
//   count                  occupancy 0..2
//   head_valid/pc/instr    head entry (registered)
module fetch_skid_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                clear,
  input  logic [PC_W-1:0]     push_pc,
  input  logic [31:0]         push_instr,
  output logic [FQ_CNT_W-1:0] count,
  output logic                head_valid,
  output logic [PC_W-1:0]     head_pc,
  output logic [31:0]         head_instr
);

  logic [PC_W-1:0]     slot_pc    [FQ_DEPTH];
  logic [31:0]         slot_instr [FQ_DEPTH];
  logic [FQ_CNT_W-1:0] count_q;
  logic                do_push;
  logic                do_pop;

  // Qualify requests: a push into a full queue is only legal alongside a pop.
  always_comb begin
    do_pop  = pop && (count_q != FQ_EMPTY);
    do_push = push && ((count_q != FQ_FULL) || do_pop);
  end

  // Storage and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= FQ_EMPTY;
      slot_pc[0]    <= {PC_W{1'b0}};
      slot_pc[1]    <= {PC_W{1'b0}};
      slot_instr[0] <= 32'h0;
      slot_instr[1] <= 32'h0;
    end else if (clear) begin
      count_q <= FQ_EMPTY;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          // count_q is 0 or 1 here, so its LSB selects the free slot
          slot_pc[count_q[0]]    <= push_pc;
          slot_instr[count_q[0]] <= push_instr;
          count_q                <= count_q + FQ_ONE;
        end
        2'b01: begin
          slot_pc[0]    <= slot_pc[1];
          slot_instr[0] <= slot_instr[1];
          count_q       <= count_q - FQ_ONE;
        end
        2'b11: begin
          if (count_q == FQ_FULL) begin
            slot_pc[0]    <= slot_pc[1];
            slot_instr[0] <= slot_instr[1];
            slot_pc[1]    <= push_pc;
            slot_instr[1] <= push_instr;
          end else begin
            slot_pc[0]    <= push_pc;
            slot_instr[0] <= push_instr;
          end
        end
        default: begin
          count_q <= count_q;
        end
      endcase
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != FQ_EMPTY);
  assign head_pc    = slot_pc[0];
  assign head_instr = slot_instr[0];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction-fetch controller: owns the PC, issues one word fetch
// at a time over imem req/ack, and buffers returned words in a 2-entry queue.
// Optional feature macro: FETCH_CTRL_PERF_EN adds perf_fetch_o / perf_stall_o.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   start_i, halt_i                 begin/resume and stop issuing fetches
//   stall_i                         decode back-pressure; head entry held
//   redirect_i, redirect_pc_i       taken branch/jump from EX
//   imem_req_o, imem_addr_o         fetch request and address
//   imem_ack_i, imem_rdata_i        one-cycle data-valid pulse and word
//   if_valid_o, if_instr_o, if_pc_o queue head toward IF/ID
//   flush_o                         squash IF/ID and ID/EX (combinational)
//   pc_o                            next address to be issued
//   perf_fetch_o, perf_stall_o      push / stall-cycle counters (macro only)
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned      PC_W     = 32,
  parameter logic [PC_W-1:0]  RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            halt_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  output logic [31:0]     if_instr_o,
  output logic [PC_W-1:0] if_pc_o,
  output logic            flush_o,
`ifdef FETCH_CTRL_PERF_EN
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_stall_o,
`endif
  output logic [PC_W-1:0] pc_o
);

  fetch_state_t        state;
  fetch_state_t        next_state;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     addr_q;
  logic                halt_pend;
  logic [FQ_CNT_W-1:0] count;
  logic [FQ_CNT_W-1:0] count_after;
  logic                pop;
  logic                push;
  logic                clear;
  logic                issue;
  logic [PC_W-1:0]     redirect_target;

  // Low two bits of the target are forced to zero (word-aligned fetch).
  assign redirect_target = redirect_pc_i & ~{{(PC_W-2){1'b0}}, 2'b11};
  assign pop             = if_valid_o && !stall_i;
  assign count_after     = occ_after_pop(count, pop);
  assign flush_o         = redirect_i;
  assign pc_o            = pc_q;

  fetch_skid_fifo #(
    .PC_W (PC_W)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .pop        (pop),
    .clear      (clear),
    .push_pc    (imem_addr_o),
    .push_instr (imem_rdata_i),
    .count      (count),
    .head_valid (if_valid_o),
    .head_pc    (if_pc_o),
    .head_instr (if_instr_o)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; redirect outranks halt, which outranks issue.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!redirect_i && start_i) next_state = ST_FETCH;
        else                        next_state = ST_IDLE;
      end
      ST_FETCH: begin
        // Nothing is ever outstanding in FETCH: an unacked issue moves to WAIT.
        if (redirect_i)                  next_state = ST_FETCH;
        else if (halt_i)                 next_state = ST_HALT;
        else if (issue && !imem_ack_i)   next_state = ST_WAIT;
        else                             next_state = ST_FETCH;
      end
      ST_WAIT: begin
        if (redirect_i) begin
          if (imem_ack_i) next_state = ST_FETCH;
          else            next_state = ST_DRAIN;
        end else if (imem_ack_i) begin
          if (halt_pend || halt_i) next_state = ST_HALT;
          else                     next_state = ST_FETCH;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        // A redirect here only retargets pc_q; the stale word is still awaited.
        if (imem_ack_i) next_state = ST_FETCH;
        else            next_state = ST_DRAIN;
      end
      ST_HALT: begin
        if (!redirect_i && start_i) next_state = ST_FETCH;
        else                        next_state = ST_HALT;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Output/control decode: memory port, queue push and clear.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = addr_q;
    issue       = 1'b0;
    push        = 1'b0;
    clear       = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_addr_o = pc_q;
        if (redirect_i) begin
          clear = 1'b1;
        end else if (halt_i) begin
          issue = 1'b0;
        end else if (count_after < FQ_FULL) begin
          // Room for the returning word even if decode keeps stalling.
          issue      = 1'b1;
          imem_req_o = 1'b1;
          push       = imem_ack_i;
        end else begin
          issue = 1'b0;
        end
      end
      ST_WAIT: begin
        imem_req_o = 1'b1;
        if (redirect_i) clear = 1'b1;
        else            push  = imem_ack_i;
      end
      ST_DRAIN: begin
        imem_req_o = 1'b1;
      end
      ST_HALT: begin
        if (redirect_i) clear = 1'b1;
        else            clear = 1'b0;
      end
      ST_IDLE: begin
        imem_req_o = 1'b0;
      end
      default: begin
        imem_req_o = 1'b0;
      end
    endcase
  end

  // PC, in-flight address and pending-halt registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      halt_pend <= 1'b0;
    end else begin
      if (redirect_i) begin
        pc_q <= redirect_target;
      end else if (issue) begin
        pc_q   <= pc_q + PC_W'(INSN_BYTES);
        addr_q <= pc_q;
      end
      // A halt seen while a fetch is in flight is remembered until the ack.
      halt_pend <= (state == ST_WAIT) && !redirect_i && !imem_ack_i &&
                   (halt_pend || halt_i);
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  // Free-running performance counters; wrap naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      if (push) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (if_valid_o && stall_i) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl -- directed bench for fetch_ctrl with a latency-programmable
// memory responder and an in-order program-stream model of delivered words.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic [31:0] pc;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  int total = 0;
  int bad   = 0;
  int lat;
  int wait_cnt;

  fetch_ctrl #(
    .PC_W     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .halt_i        (halt),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .if_valid_o    (if_valid),
    .if_instr_o    (if_instr),
    .if_pc_o       (if_pc),
    .flush_o       (flush),
`ifdef FETCH_CTRL_PERF_EN
    .perf_fetch_o  (perf_fetch),
    .perf_stall_o  (perf_stall),
`endif
    .pc_o          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: every word is a simple function of its address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: acks when the request has been up for 'lat' cycles (0 = same cycle).
  assign imem_ack   = imem_req && (wait_cnt == lat);
  assign imem_rdata = memf(imem_addr);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},    {31'h0, imem_req}, 32'h0);
    chk({tag, "_valid"},  {31'h0, if_valid}, 32'h0);
    chk({tag, "_instr"},  if_instr, 32'h0);
    chk({tag, "_if_pc"},  if_pc, 32'h0);
    chk({tag, "_flush"},  {31'h0, flush}, 32'h0);
    chk({tag, "_pc_o"},   pc, 32'h0);
`ifdef FETCH_CTRL_PERF_EN
    chk({tag, "_perf_fetch"}, perf_fetch, 32'h0);
    chk({tag, "_perf_stall"}, perf_stall, 32'h0);
`endif
  endtask

  // Stream model: delivered words must be the program in order from the last
  // redirect target (or reset PC), each exactly once; requests hold their
  // address until acked; flush mirrors redirect.
  logic [31:0] exp_pc;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;

  initial begin
    exp_pc   = 32'h0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc   = 32'h0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        chk("flush_vs_redirect", {31'h0, flush}, {31'h0, redirect});
        if (prev_req && !prev_ack && imem_req)
          chk("addr_hold", imem_addr, prev_addr);
        if (redirect) begin
          exp_pc = {redirect_pc[31:2], 2'b00};
        end else if (if_valid && !stall) begin
          chk("pop_pc", if_pc, exp_pc);
          chk("pop_instr", if_instr, memf(exp_pc));
          exp_pc = exp_pc + 32'd4;
        end
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
      end
    end
  end

  logic [15:0] stall_pat;

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; lat = 0;
    stall_pat = 16'b0010_1100_0110_0000;
    tick(); tick();
    settle();
    check_reset_vals("reset");

    // T0: start in IDLE, zero-wait memory
    rst = 1'b0; start = 1'b1; settle();
    chk("t0_no_req", {31'h0, imem_req}, 32'h0);
    tick(); start = 1'b0; settle();                      // T1
    chk("t1_req", {31'h0, imem_req}, 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_valid", {31'h0, if_valid}, 32'h0);
    tick(); settle(); chk("t2_pc", if_pc, 32'h0);
    chk("t2_valid", {31'h0, if_valid}, 32'h1);
    tick(); settle(); chk("t3_pc", if_pc, 32'h4);
    tick(); settle(); chk("t4_pc", if_pc, 32'h8);
    tick(); settle(); chk("t5_pc", if_pc, 32'hC);

    // Decode stall for 5 cycles (T5..T9): queue fills, req drops, head held
    stall = 1'b1;
    repeat (4) tick();
    settle();                                            // T9
    chk("stall_req", {31'h0, imem_req}, 32'h0);
    chk("stall_head", if_pc, 32'hC);
    chk("stall_valid", {31'h0, if_valid}, 32'h1);
    tick(); stall = 1'b0; settle();                      // T10
    chk("t10_pc", if_pc, 32'hC);
    tick(); settle(); chk("t11_pc", if_pc, 32'h10);
    tick(); settle(); chk("t12_pc", if_pc, 32'h14);
    tick(); settle(); chk("t13_pc", if_pc, 32'h18);

    // Memory with 3-cycle latency: request to 0x20 issued at T13
    lat = 3; settle();
    tick(); settle();                                    // T14
    chk("t14_req", {31'h0, imem_req}, 32'h1);
    chk("t14_addr", imem_addr, 32'h20);
    tick(); settle();                                    // T15
    chk("t15_valid", {31'h0, if_valid}, 32'h0);
    chk("t15_addr", imem_addr, 32'h20);
    tick(); settle();                                    // T16
    chk("t16_ack", {31'h0, imem_ack}, 32'h1);
    chk("t16_addr", imem_addr, 32'h20);
    tick(); settle();                                    // T17
    chk("t17_valid", {31'h0, if_valid}, 32'h1);
    chk("t17_pc", if_pc, 32'h20);

    // Redirect to 0x103 while the fetch of 0x24 is outstanding
    tick(); redirect = 1'b1; redirect_pc = 32'h103; settle();   // T18
    chk("redir_flush", {31'h0, flush}, 32'h1);
    chk("redir_addr", imem_addr, 32'h24);
    tick(); redirect = 1'b0; settle();                   // T19
    chk("drain_flush", {31'h0, flush}, 32'h0);
    chk("drain_req", {31'h0, imem_req}, 32'h1);
    chk("drain_addr", imem_addr, 32'h24);
    chk("drain_valid", {31'h0, if_valid}, 32'h0);
    tick(); settle();                                    // T20
    chk("drain_ack", {31'h0, imem_ack}, 32'h1);
    chk("drain_valid2", {31'h0, if_valid}, 32'h0);
    tick(); lat = 0; settle();                           // T21
    chk("target_valid", {31'h0, if_valid}, 32'h0);
    chk("target_req", {31'h0, imem_req}, 32'h1);
    chk("target_addr", imem_addr, 32'h100);
    tick(); settle();                                    // T22
    chk("target_pc", if_pc, 32'h100);
    chk("target_instr", if_instr, 32'hC0DE_0100);

    // Halt while the fetch of 0x104 is in flight
    stall = 1'b1; lat = 3; settle();
    tick(); halt = 1'b1; settle();                       // T23
    chk("halt_req", {31'h0, imem_req}, 32'h1);
    chk("halt_addr", imem_addr, 32'h104);
    tick(); halt = 1'b0;                                 // T24
    tick(); settle();                                    // T25
    chk("halt_ack", {31'h0, imem_ack}, 32'h1);
    tick(); settle();                                    // T26
    chk("halted_req", {31'h0, imem_req}, 32'h0);
    chk("halted_pc", if_pc, 32'h100);
    tick(); stall = 1'b0; settle();                      // T27
    chk("halted_req2", {31'h0, imem_req}, 32'h0);
    tick(); settle(); chk("halt_drain_pc", if_pc, 32'h104);   // T28
    tick(); start = 1'b1; lat = 0; settle();             // T29
    chk("halt_empty", {31'h0, if_valid}, 32'h0);
    chk("halt_no_req", {31'h0, imem_req}, 32'h0);
    tick(); start = 1'b0; settle();                      // T30
    chk("resume_req", {31'h0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h108);
    tick(); settle(); chk("resume_pc", if_pc, 32'h108);  // T31

    // Reset in the middle of a WAIT
    lat = 3; settle();
    tick(); settle();                                    // T32
    chk("wait_req", {31'h0, imem_req}, 32'h1);
    chk("wait_addr", imem_addr, 32'h10C);
    rst = 1'b1;
    tick(); settle();                                    // T33
    check_reset_vals("midwait_reset");

    // Redirect while IDLE only retargets the PC
    rst = 1'b0; redirect = 1'b1; redirect_pc = 32'h202; settle();
    chk("idle_flush", {31'h0, flush}, 32'h1);
    chk("idle_redir_req", {31'h0, imem_req}, 32'h0);
    tick(); redirect = 1'b0; settle();                   // T34
    chk("idle_pc_o", pc, 32'h200);
    chk("idle_still", {31'h0, imem_req}, 32'h0);
    start = 1'b1; lat = 0;
    tick(); start = 1'b0; settle();                      // T35
    chk("idle_start_addr", imem_addr, 32'h200);

    // Mixed stall pattern with zero-wait memory; the stream model checks order
    for (int i = 0; i < 16; i++) begin
      stall = stall_pat[i];
      tick();
    end
    stall = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
